// File: rtl/not_not_pkg.sv
// Shared definitions for the Not Not game: round controller states and colour width.
package not_not_pkg;

    // One bit per LED colour; the prompt generator uses the same width.
    localparam int COLOR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_JUDGE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    // States in which a game round is in progress.
    function automatic logic is_playing(state_t s);
        return (s == ST_LOAD) || (s == ST_ARM) || (s == ST_WAIT) || (s == ST_JUDGE);
    endfunction

endpackage

// File: rtl/round_judge_if.sv
// Player/prompt-facing signal bundle of the round controller.
interface round_judge_if #(
    parameter int SCORE_W = 8,
    parameter int LIVES_W = 2
) ();
    import not_not_pkg::*;

    logic               start;
    logic [COLOR_W-1:0] expected;
    logic [COLOR_W-1:0] answer;
    logic               submit;
    logic               new_round;
    logic               result_valid;
    logic               result_correct;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               playing;
    logic               game_over;

    // Master drives the game inputs and observes the judge.
    modport master (
        output start, expected, answer, submit,
        input  new_round, result_valid, result_correct, score, lives, playing, game_over
    );

    // Slave is the round controller itself.
    modport slave (
        input  start, expected, answer, submit,
        output new_round, result_valid, result_correct, score, lives, playing, game_over
    );
endinterface

// File: rtl/round_judge_timer.sv
// Per-round down-counter: loads ROUND_TICKS-1 and counts towards zero.
module round_timer #(
    parameter int ROUND_TICKS = 100000000,
    parameter int TIMER_W     = 27
) (
    input  logic clock,
    input  logic resetn,
    input  logic load,
    input  logic run,
    output logic expired
);
    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Load wins over run; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TIMER_W'(ROUND_TICKS - 1);
        end else if (run && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);
endmodule

// File: rtl/round_judge.sv
// Not Not round controller: sequences rounds, judges answers, keeps score and lives.
module round_judge
    import not_not_pkg::*;
#(
    parameter int ROUND_TICKS = 100000000,
    parameter int TIMER_W     = 27,
    parameter int SCORE_W     = 8,
    parameter int LIVES_W     = 2,
    parameter int MAX_LIVES   = 3
) (
    input  logic          clock,
    input  logic          resetn,
    round_judge_if.slave  bus
);
    state_t             state_q, state_d;
    logic [COLOR_W-1:0] exp_q, exp_d;
    logic [COLOR_W-1:0] ans_q, ans_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               new_round_q, new_round_d;
    logic               result_valid_q, result_valid_d;
    logic               result_correct_q, result_correct_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic               timer_load, timer_run, timer_expired;

    round_timer #(
        .ROUND_TICKS (ROUND_TICKS),
        .TIMER_W     (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .load    (timer_load),
        .run     (timer_run),
        .expired (timer_expired)
    );

    // Next state, datapath updates, and outputs decoded from the next state so they register cleanly.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        ans_d      = ans_q;
        score_d    = score_q;
        lives_d    = lives_q;
        timer_load = 1'b0;
        timer_run  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    score_d = '0;
                    lives_d = LIVES_W'(MAX_LIVES);
                end
            end
            ST_LOAD: state_d = ST_ARM;
            ST_ARM: begin
                exp_d      = bus.expected;
                timer_load = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A submit coinciding with expiry is simply a submit; both sample answer.
                if (bus.submit || timer_expired) begin
                    ans_d   = bus.answer;
                    state_d = ST_JUDGE;
                end else begin
                    timer_run = 1'b1;
                end
            end
            ST_JUDGE: begin
                if (ans_q == exp_q) begin
                    if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    state_d = ST_LOAD;
                end else begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        new_round_d      = (state_d == ST_LOAD);
        result_valid_d   = (state_d == ST_JUDGE);
        result_correct_d = (state_d == ST_JUDGE) && (ans_d == exp_q);
        playing_d        = is_playing(state_d);
        game_over_d      = (state_d == ST_OVER);
    end

    // State and registered outputs; reset aborts any round in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            exp_q            <= '0;
            ans_q            <= '0;
            score_q          <= '0;
            lives_q          <= LIVES_W'(MAX_LIVES);
            new_round_q      <= 1'b0;
            result_valid_q   <= 1'b0;
            result_correct_q <= 1'b0;
            playing_q        <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            exp_q            <= exp_d;
            ans_q            <= ans_d;
            score_q          <= score_d;
            lives_q          <= lives_d;
            new_round_q      <= new_round_d;
            result_valid_q   <= result_valid_d;
            result_correct_q <= result_correct_d;
            playing_q        <= playing_d;
            game_over_q      <= game_over_d;
        end
    end

    assign bus.new_round      = new_round_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result_correct = result_correct_q;
    assign bus.score          = score_q;
    assign bus.lives          = lives_q;
    assign bus.playing        = playing_q;
    assign bus.game_over      = game_over_q;
endmodule
